// File: rtl/store_drain_unit_pkg.sv
// Shared types for the retired-store drain path: buffer entry, bus encodings, drain FSM states.
// Optional statistics counters in the top are enabled with STORE_DRAIN_STATS_EN.
package store_drain_unit_pkg;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] value;
    } SQ_ENTRY_PACKET;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'h0,
        REQ  = 2'h1,
        POP  = 2'h2
    } drain_state_e;

endpackage

// File: rtl/store_drain_unit_lane_pack.sv
// Places a 32-bit store value into its lane of the 64-bit bus word and aligns the address.
module store_lane_pack (
    input  logic [31:0] addr_i,
    input  logic [31:0] value_i,
    output logic [31:0] addr_o,
    output logic [63:0] data_o
);

    assign addr_o = {addr_i[31:3], 3'b000};
    assign data_o = addr_i[2] ? {value_i, 32'h0000_0000} : {32'h0000_0000, value_i};

endmodule

// File: rtl/store_drain_unit.sv
// Drains committed stores from the retire buffer head onto the memory bus, yielding to loads.
// Define STORE_DRAIN_STATS_EN to add the stat_stores / stat_stall_cycles debug counters.
module store_drain_unit
    import store_drain_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           sb_empty,
    input  SQ_ENTRY_PACKET sb_entry,
    output logic           sb_rd_en,
    input  logic           ld_req,
    output BUS_COMMAND     proc2mem_command,
    output logic [31:0]    proc2mem_addr,
    output logic [63:0]    proc2mem_data,
    output MEM_SIZE        proc2mem_size,
    input  logic [3:0]     mem2proc_response,
    output logic           st_bus_busy,
    output logic           drained,
    output logic           timeout_err
`ifdef STORE_DRAIN_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_stores,
    output logic [CNT_W-1:0] stat_stall_cycles
`endif
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

    drain_state_e       state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_err_q, timeout_err_d;
    logic [31:0]        pack_addr;
    logic [63:0]        pack_data;
    logic               driving;
    logic               accepted;

    store_lane_pack u_lane_pack (
        .addr_i  (sb_entry.addr),
        .value_i (sb_entry.value),
        .addr_o  (pack_addr),
        .data_o  (pack_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        stall_d          = stall_q;
        timeout_err_d    = timeout_err_q;
        driving          = 1'b0;
        accepted         = 1'b0;
        sb_rd_en         = 1'b0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        st_bus_busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sb_empty && !ld_req) state_d = REQ;
            end
            REQ: begin
                // An empty head here can only mean the buffer was flushed under us; never pop it.
                if (sb_empty) begin
                    state_d = IDLE;
                end else begin
                    driving  = !ld_req;
                    accepted = driving && (mem2proc_response != 4'h0);
                    if (driving) begin
                        proc2mem_command = BUS_STORE;
                        proc2mem_addr    = pack_addr;
                        proc2mem_data    = pack_data;
                        st_bus_busy      = 1'b1;
                    end
                    if (accepted) begin
                        sb_rd_en = 1'b1;
                        stall_d  = '0;
                        state_d  = POP;
                    end else if (stall_q != STALL_MAX) begin
                        stall_d = stall_q + 1'b1;
                    end
                    if (stall_d == STALL_MAX) timeout_err_d = 1'b1;
                end
            end
            POP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign proc2mem_size = WORD;
    assign drained       = (state_q == IDLE) && sb_empty;
    assign timeout_err   = timeout_err_q;

`ifdef STORE_DRAIN_STATS_EN
    logic [CNT_W-1:0] stat_stores_q;
    logic [CNT_W-1:0] stat_stall_q;
    logic             stall_cycle;

    // Yield cycles count as stalls: the store is pending but not on the bus.
    assign stall_cycle = (state_q == REQ) && !sb_empty && !accepted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_stores_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (accepted && (stat_stores_q != '1)) stat_stores_q <= stat_stores_q + 1'b1;
            if (stall_cycle && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 1'b1;
        end
    end

    assign stat_stores       = stat_stores_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit: a queue stands in for the retire store buffer.
module tb_store_drain_unit;
    import store_drain_unit_pkg::*;

    logic           clock;
    logic           reset;
    logic           sb_empty;
    SQ_ENTRY_PACKET sb_entry;
    logic           sb_rd_en;
    logic           ld_req;
    BUS_COMMAND     proc2mem_command;
    logic [31:0]    proc2mem_addr;
    logic [63:0]    proc2mem_data;
    MEM_SIZE        proc2mem_size;
    logic [3:0]     mem2proc_response;
    logic           st_bus_busy;
    logic           drained;
    logic           timeout_err;
`ifdef STORE_DRAIN_STATS_EN
    logic [15:0]    stat_stores;
    logic [15:0]    stat_stall_cycles;
`endif

    store_drain_unit #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .sb_empty          (sb_empty),
        .sb_entry          (sb_entry),
        .sb_rd_en          (sb_rd_en),
        .ld_req            (ld_req),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response),
        .st_bus_busy       (st_bus_busy),
        .drained           (drained),
        .timeout_err       (timeout_err)
`ifdef STORE_DRAIN_STATS_EN
        ,
        .stat_stores       (stat_stores),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    SQ_ENTRY_PACKET sb_q[$];
    logic [31:0]    exp_q[$];
    logic [63:0]    exp_d_q[$];
    int errors = 0;
    int checks = 0;
    int pops = 0;
    int rd_empty_cnt = 0;
    int rd_adj_cnt = 0;
    int pops_before = 0;
    int stores_seen = 0;
    logic prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        sb_empty = (sb_q.size() == 0);
        sb_entry = (sb_q.size() != 0) ? sb_q[0] : '0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] v);
        SQ_ENTRY_PACKET e;
        e.addr  = a;
        e.value = v;
        sb_q.push_back(e);
        refresh();
    endtask

    // One clock: sample the pop request before the edge, apply it to the buffer model after.
    task automatic tick();
        logic p;
        #1;
        p = sb_rd_en;
        if (p && (sb_q.size() == 0)) rd_empty_cnt++;
        if (p && prev_rd) rd_adj_cnt++;
        prev_rd = p;
        @(posedge clock);
        #1;
        if (p && (sb_q.size() != 0)) begin
            void'(sb_q.pop_front());
            pops++;
        end
        refresh();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ld_req = 1'b0;
        mem2proc_response = 4'h0;
        refresh();
        push(32'h0000_1004, 32'hDEAD_BEEF);
        tick();
        tick();
        chk("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("rst_addr", 64'(proc2mem_addr), 64'h0);
        chk("rst_data", proc2mem_data, 64'h0);
        chk("rst_busy", 64'(st_bus_busy), 64'h0);
        chk("rst_rd", 64'(sb_rd_en), 64'h0);
        chk("rst_err", 64'(timeout_err), 64'h0);
        chk("rst_size", 64'(proc2mem_size), 64'(WORD));

        // First store after reset, accepted on the first REQ cycle.
        reset = 1'b0;
        mem2proc_response = 4'h1;
        tick();
        chk("t1_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        chk("t1_addr", 64'(proc2mem_addr), 64'h1000);
        chk("t1_data", proc2mem_data, 64'hDEAD_BEEF_0000_0000);
        chk("t1_busy", 64'(st_bus_busy), 64'h1);
        chk("t1_rd", 64'(sb_rd_en), 64'h1);
        chk("t1_drained_req", 64'(drained), 64'h0);
        tick();
        chk("t1_pop_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t1_pop_rd", 64'(sb_rd_en), 64'h0);
        chk("t1_pop_drained", 64'(drained), 64'h0);
        tick();
        chk("t1_drained", 64'(drained), 64'h1);
        chk("t1_pops", 64'(pops), 64'd1);

        // Three queued stores, immediate acceptance, FIFO order.
        push(32'h0000_2000, 32'h1111_1111);
        push(32'h0000_2008, 32'h2222_2222);
        push(32'h0000_200C, 32'h3333_3333);
        exp_q.push_back(32'h0000_2000);
        exp_q.push_back(32'h0000_2008);
        exp_q.push_back(32'h0000_2008);
        exp_d_q.push_back(64'h0000_0000_1111_1111);
        exp_d_q.push_back(64'h0000_0000_2222_2222);
        exp_d_q.push_back(64'h3333_3333_0000_0000);
        pops_before = pops;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (proc2mem_command == BUS_STORE) begin
                stores_seen++;
                if (exp_q.size() != 0) begin
                    chk("t2_addr", 64'(proc2mem_addr), 64'(exp_q.pop_front()));
                    chk("t2_data", proc2mem_data, exp_d_q.pop_front());
                end
            end
            tick();
        end
        chk("t2_stores", 64'(stores_seen), 64'd3);
        chk("t2_pops", 64'(pops - pops_before), 64'd3);
        chk("t2_drained", 64'(drained), 64'h1);

        // Yield to loads for 5 cycles while in REQ.
        mem2proc_response = 4'h0;
        push(32'h0000_3010, 32'hCAFE_F00D);
        tick();
        ld_req = 1'b1;
        mem2proc_response = 4'h1;
        pops_before = pops;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_yield_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
            chk("t3_yield_busy", 64'(st_bus_busy), 64'h0);
            chk("t3_yield_rd", 64'(sb_rd_en), 64'h0);
            tick();
        end
        chk("t3_no_pop", 64'(pops - pops_before), 64'd0);
        ld_req = 1'b0;
        #1;
        chk("t3_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        chk("t3_addr", 64'(proc2mem_addr), 64'h3010);
        chk("t3_data", proc2mem_data, 64'h0000_0000_CAFE_F00D);
        chk("t3_rd", 64'(sb_rd_en), 64'h1);
        tick();
        mem2proc_response = 4'h0;
        tick();
        chk("t3_pops", 64'(pops - pops_before), 64'd1);
        chk("t3_err", 64'(timeout_err), 64'h0);

        // No response for 64 REQ cycles: sticky timeout error.
        push(32'h0000_4004, 32'h0BAD_C0DE);
        pops_before = pops;
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("t4_err_63", 64'(timeout_err), 64'h0);
        tick();
        chk("t4_err_64", 64'(timeout_err), 64'h1);
        mem2proc_response = 4'h2;
        #1;
        chk("t4_cmd", 64'(proc2mem_command), 64'(BUS_STORE));
        chk("t4_addr", 64'(proc2mem_addr), 64'h4000);
        chk("t4_data", proc2mem_data, 64'h0BAD_C0DE_0000_0000);
        chk("t4_rd", 64'(sb_rd_en), 64'h1);
        tick();
        mem2proc_response = 4'h0;
        chk("t4_err_pop", 64'(timeout_err), 64'h1);
        tick();
        chk("t4_err_idle", 64'(timeout_err), 64'h1);
        chk("t4_pops", 64'(pops - pops_before), 64'd1);
        chk("t4_drained", 64'(drained), 64'h1);

        // Asynchronous reset while a store is pending on the bus.
        push(32'h0000_5000, 32'h5555_5555);
        pops_before = pops;
        tick();
        tick();
        tick();
        chk("t5_busy_pre", 64'(st_bus_busy), 64'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("t5_busy", 64'(st_bus_busy), 64'h0);
        chk("t5_rd", 64'(sb_rd_en), 64'h0);
        chk("t5_addr", 64'(proc2mem_addr), 64'h0);
        chk("t5_data", proc2mem_data, 64'h0);
        chk("t5_err", 64'(timeout_err), 64'h0);
        chk("t5_drained", 64'(drained), 64'h0);
        tick();
        tick();
        chk("t5_no_pop", 64'(pops - pops_before), 64'd0);
        chk("t5_entry_kept", 64'(sb_q.size()), 64'd1);

        // Two stores with 2 + 2 stall cycles (one of them a yield).
        reset = 1'b0;
`ifdef STORE_DRAIN_STATS_EN
        #1;
        chk("t6_stores_rst", 64'(stat_stores), 64'd0);
        chk("t6_stall_rst", 64'(stat_stall_cycles), 64'd0);
`endif
        tick();
        tick();
        tick();
        mem2proc_response = 4'h1;
        tick();
        mem2proc_response = 4'h0;
        tick();
        push(32'h0000_6004, 32'h6666_6666);
        tick();
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        tick();
        mem2proc_response = 4'h1;
        tick();
        mem2proc_response = 4'h0;
        tick();
        chk("t6_pops", 64'(pops - pops_before), 64'd2);
        chk("t6_drained", 64'(drained), 64'h1);
        chk("t6_err", 64'(timeout_err), 64'h0);
`ifdef STORE_DRAIN_STATS_EN
        chk("t6_stat_stores", 64'(stat_stores), 64'd2);
        chk("t6_stat_stall", 64'(stat_stall_cycles), 64'd4);
`endif

        chk("rd_while_empty", 64'(rd_empty_cnt), 64'd0);
        chk("rd_adjacent", 64'(rd_adj_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
